// File: rtl/lap_stopwatch.sv
// Stopwatch core: self-timed tick, mixed-radix BCD up/down counter with
// wrap or saturate at the limits, and a lap freeze of the displayed value.
module lap_stopwatch #(
  parameter int unsigned           TICK_DIV    = 10_000_000,
  parameter int unsigned           NUM_DIGITS  = 4,
  parameter logic [NUM_DIGITS-1:0] RADIX6_MASK = NUM_DIGITS'(4'b0100),
  parameter bit                    WRAP        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    clr,
  input  logic                    up,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [4*NUM_DIGITS-1:0] disp,
  output logic                    lap_active,
  output logic                    tick,
  output logic                    at_limit
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = 4 * NUM_DIGITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lap_reg_q, lap_reg_d;
  logic          lap_active_q, lap_active_d;
  logic          lap_q;

  logic [CW-1:0] step_c;
  logic          at_limit_c;
  logic          tick_c;
  logic          lap_edge_c;

  // Ripple step: a digit moves only while every lower digit sits at its
  // terminal value; the carry out of the top digit is the limit flag.
  always_comb begin : step_logic
    logic       carry;
    logic [3:0] dig;
    logic [3:0] dmax;
    carry  = 1'b1;
    dig    = 4'd0;
    dmax   = 4'd9;
    step_c = cnt_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig  = cnt_q[4*i +: 4];
      dmax = RADIX6_MASK[i] ? 4'd5 : 4'd9;
      if (carry) begin
        if (up) begin
          step_c[4*i +: 4] = (dig == dmax) ? 4'd0 : dig + 4'd1;
        end else begin
          step_c[4*i +: 4] = (dig == 4'd0) ? dmax : dig - 4'd1;
        end
      end
      carry = carry & (up ? (dig == dmax) : (dig == 4'd0));
    end
    at_limit_c = carry;
  end

  assign tick_c     = go && (div_q == DIV_LAST);
  assign lap_edge_c = lap & ~lap_q;

  // Next-state: clear dominates; otherwise divider, count and lap advance.
  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    lap_reg_d    = lap_reg_q;
    lap_active_d = lap_active_q;
    if (clr) begin
      div_d        = '0;
      cnt_d        = '0;
      lap_reg_d    = '0;
      lap_active_d = 1'b0;
    end else begin
      if (go) begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (tick_c && !(at_limit_c && !WRAP)) begin
        cnt_d = step_c;
      end
      if (lap_edge_c) begin
        lap_active_d = ~lap_active_q;
        if (!lap_active_q) begin
          lap_reg_d = cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      cnt_q        <= '0;
      lap_reg_q    <= '0;
      lap_active_q <= 1'b0;
      lap_q        <= 1'b0;
    end else begin
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      lap_reg_q    <= lap_reg_d;
      lap_active_q <= lap_active_d;
      lap_q        <= lap;
    end
  end

  assign digits     = cnt_q;
  assign disp       = lap_active_q ? lap_reg_q : cnt_q;
  assign lap_active = lap_active_q;
  assign tick       = tick_c;
  assign at_limit   = at_limit_c;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: a wrapping and a saturating instance share stimulus
// and are compared every cycle against an integer-count model.
module tb_lap_stopwatch;

  localparam int unsigned TD = 4;
  localparam int unsigned ND = 4;
  localparam int unsigned W  = 4 * ND;
  localparam int          M  = 6000;
  localparam logic [3:0]  MASK = 4'b0100;

  logic         clk = 1'b0;
  logic         reset = 1'b1, go = 1'b0, clr = 1'b0, up = 1'b1, lap = 1'b0;
  logic [W-1:0] digits0, disp0, digits1, disp1;
  logic         la0, la1, tick0, tick1, al0, al1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(.TICK_DIV(TD), .NUM_DIGITS(ND), .RADIX6_MASK(MASK), .WRAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .lap(lap),
    .digits(digits0), .disp(disp0), .lap_active(la0), .tick(tick0), .at_limit(al0)
  );

  lap_stopwatch #(.TICK_DIV(TD), .NUM_DIGITS(ND), .RADIX6_MASK(MASK), .WRAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .lap(lap),
    .digits(digits1), .disp(disp1), .lap_active(la1), .tick(tick1), .at_limit(al1)
  );

  // Model: the count is a plain integer 0..M-1, digits derived by division.
  int m_val[2], m_div[2], m_lapv[2];
  bit m_lapa[2], m_lapq[2];
  bit started = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    int rad;
    r = '0;
    x = v;
    for (int i = 0; i < int'(ND); i++) begin
      rad = MASK[i] ? 6 : 10;
      r[4*i +: 4] = 4'(x % rad);
      x = x / rad;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit tk, ed, wrap;
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wrap = (k == 0);
      if (reset) begin
        m_val[k] = 0; m_div[k] = 0; m_lapv[k] = 0; m_lapa[k] = 0; m_lapq[k] = 0;
      end else begin
        tk = go && (m_div[k] == int'(TD) - 1);
        ed = lap && !m_lapq[k];
        m_lapq[k] = lap;
        if (clr) begin
          m_val[k] = 0; m_div[k] = 0; m_lapv[k] = 0; m_lapa[k] = 0;
        end else begin
          if (ed) begin
            if (!m_lapa[k]) begin m_lapv[k] = m_val[k]; m_lapa[k] = 1; end
            else m_lapa[k] = 0;
          end
          if (go) m_div[k] = (m_div[k] + 1) % int'(TD);
          if (tk) begin
            if (up) m_val[k] = (m_val[k] == M - 1) ? (wrap ? 0 : m_val[k]) : m_val[k] + 1;
            else    m_val[k] = (m_val[k] == 0) ? (wrap ? M - 1 : 0) : m_val[k] - 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic [W-1:0] e_dig, e_disp;
        bit e_tick, e_al;
        e_dig  = to_bcd(m_val[k]);
        e_disp = m_lapa[k] ? to_bcd(m_lapv[k]) : e_dig;
        e_tick = go && (m_div[k] == int'(TD) - 1);
        e_al   = up ? (m_val[k] == M - 1) : (m_val[k] == 0);
        if (k == 0) begin
          chk("m0_digits", digits0, e_dig);
          chk("m0_disp", disp0, e_disp);
          chk("m0_lap_active", W'(la0), W'(m_lapa[k]));
          chk("m0_tick", W'(tick0), W'(e_tick));
          chk("m0_at_limit", W'(al0), W'(e_al));
          chk("m0_div", W'(dut0.div_q), W'(m_div[k]));
        end else begin
          chk("m1_digits", digits1, e_dig);
          chk("m1_disp", disp1, e_disp);
          chk("m1_lap_active", W'(la1), W'(m_lapa[k]));
          chk("m1_tick", W'(tick1), W'(e_tick));
          chk("m1_at_limit", W'(al1), W'(e_al));
          chk("m1_div", W'(dut1.div_q), W'(m_div[k]));
        end
      end
    end
  end

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_val(input logic [W-1:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (digits0 !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, digits0, target);
  endtask

  // Wait for the next tick of instance 0, then land in the following cycle.
  task automatic after_tick(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!tick0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_tick_seen"}, W'(tick0), W'(1'b1));
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; go = 1'b0; up = 1'b0; clr = 1'b0; lap = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", digits0, '0);
    chk("rst_disp", disp0, '0);
    chk("rst_lap_active", W'(la0), '0);
    chk("rst_at_limit_down", W'(al0), W'(1'b1));

    step_in(); reset = 1'b0; go = 1'b1; up = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("count_40_cycles", digits0, 16'h0010);

    wait_val(16'h0123, 500, "reach_0123");
    step_in(); reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_digits", digits0, '0);
    chk("midreset_tick", W'(tick0), '0);
    step_in(); reset = 1'b0;
    n = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tick0) break;
    end
    chk("first_tick_cycle", W'(n), W'(3));

    wait_val(16'h0599, 3000, "reach_0599");
    after_tick("roll_minute");
    chk("minute_rollover", digits0, 16'h1000);
    wait_val(16'h9599, 22000, "reach_9599");
    chk("top_at_limit", W'(al0), W'(1'b1));
    after_tick("wrap_top");
    chk("wrap_to_zero", digits0, 16'h0000);
    chk("sat_holds_top", digits1, 16'h9599);

    step_in(); clr = 1'b1;
    step_in(); clr = 1'b0; up = 1'b0;
    after_tick("down0");
    chk("down_wrap", digits0, 16'h9599);
    for (int t = 0; t < 4; t++) begin
      after_tick("down_sat");
      chk("sat_digits", digits1, 16'h0000);
      chk("sat_at_limit", W'(al1), W'(1'b1));
    end
    step_in(); up = 1'b1;
    after_tick("release");
    chk("sat_release", digits1, 16'h0001);

    step_in(); clr = 1'b1;
    step_in(); clr = 1'b0;
    wait_val(16'h0012, 200, "reach_0012");
    step_in(); lap = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lap_frozen", disp0, 16'h0012);
    chk("lap_active_on", W'(la0), W'(1'b1));
    wait_val(16'h0015, 40, "reach_0015");
    chk("lap_still_frozen", disp0, 16'h0012);
    chk("lap_held_no_toggle", W'(la0), W'(1'b1));
    step_in(); lap = 1'b0;
    step_in(); lap = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lap_released", W'(la0), '0);
    chk("lap_disp_live", disp0, to_bcd(m_val[0]));

    step_in(); lap = 1'b0; clr = 1'b1; go = 1'b0;
    step_in(); clr = 1'b0; go = 1'b1;
    repeat (2) @(posedge clk);
    #1 go = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("pause_no_tick", W'(tick0), '0);
      chk("pause_div_hold", W'(dut0.div_q), W'(2));
    end
    step_in(); go = 1'b1;
    @(negedge clk);
    chk("resume_no_tick", W'(tick0), '0);
    @(negedge clk);
    chk("resume_tick", W'(tick0), W'(1'b1));

    n = 0;
    while (dut0.div_q != 2'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    step_in(); clr = 1'b1; lap = 1'b1;
    @(negedge clk);
    chk("clr_tick_cycle", W'(tick0), W'(1'b1));
    step_in(); clr = 1'b0;
    @(negedge clk);
    chk("clr_digits", digits0, '0);
    chk("clr_disp", disp0, '0);
    chk("clr_lap_active", W'(la0), '0);
    chk("clr_div", W'(dut0.div_q), '0);
    @(negedge clk);
    chk("clr_lap_no_retrigger", W'(la0), '0);

    step_in(); up = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step_in();
      go    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) up = ~up;
      if ($urandom_range(0, 15) == 0) lap = ~lap;
      clr   = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end
    step_in(); reset = 1'b0; clr = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
